// File: rtl/ptp_ts_word_fifo_pkg.sv
// ============================================================================
// Module      : ptp_ts_word_fifo_pkg
// Description : Shared widths, output FSM state type and word-slice helper for
//               the PTP timestamp word FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ptp_ts_word_fifo_pkg;

  localparam int TS_W         = 96;
  localparam int WORD_W       = 32;
  localparam int WORDS_PER_TS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_W0   = 2'd1,
    ST_W1   = 2'd2,
    ST_W2   = 2'd3
  } out_state_e;

  // Word 0 is the most significant slice (seconds high bits go out first).
  function automatic logic [WORD_W-1:0] ts_word(input logic [TS_W-1:0] ts, input int idx);
    return ts[WORD_W*(WORDS_PER_TS-1-idx) +: WORD_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ptp_ts_word_fifo_if.sv
// ============================================================================
// Module      : ptp_ts_word_fifo_if
// Description : Timestamp input stream and 32-bit AXI-Stream output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ptp_ts_word_fifo_if
  import ptp_ts_word_fifo_pkg::*;
();

  logic [TS_W-1:0]   s_axis_ts_96;
  logic              s_axis_ts_valid;
  logic              s_axis_ts_ready;
  logic [WORD_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  // The FIFO itself: consumes timestamps, produces words.
  modport slave (
    input  s_axis_ts_96,
    input  s_axis_ts_valid,
    output s_axis_ts_ready,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast
  );

  // The surrounding system: MAC timestamp source plus stream sink.
  modport master (
    output s_axis_ts_96,
    output s_axis_ts_valid,
    input  s_axis_ts_ready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast
  );

endinterface

`default_nettype wire

// File: rtl/ptp_ts_word_fifo_ram.sv
// ============================================================================
// Module      : ptp_ts_fifo_ram
// Description : DEPTH x 96 simple dual-port storage, synchronous write,
//               asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ptp_ts_fifo_ram
  import ptp_ts_word_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [TS_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [TS_W-1:0]   rd_data
);

  logic [TS_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/ptp_ts_word_fifo.sv
// ============================================================================
// Module      : ptp_ts_word_fifo
// Description : Buffers 96-bit PTP timestamps and serialises each into three
//               32-bit AXI-Stream words. Optional macro PTP_TS_FIFO_DROP_EN
//               drops pushes while full and counts them instead of stalling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ptp_ts_word_fifo
  import ptp_ts_word_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  ptp_ts_word_fifo_if.slave bus,
  output logic [ADDR_W:0]   fill_level,
  output logic [CNT_W-1:0]  overflow_count
);

  localparam logic [ADDR_W:0] c_PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_ready_en;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [TS_W-1:0]   w_rd_data;
  logic [TS_W-1:0]   r_hold;
  out_state_e        r_state;
  out_state_e        w_state_nxt;
  logic [WORD_W-1:0] w_tdata;
  logic              w_tvalid;
  logic              w_tlast;

  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // Holds ready low through reset and releases it on the first clock after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

`ifdef PTP_TS_FIFO_DROP_EN
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_overflow_count;

  assign bus.s_axis_ts_ready = r_ready_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow_count <= '0;
    end else if (bus.s_axis_ts_valid && r_ready_en && w_full && !(&r_overflow_count)) begin
      r_overflow_count <= r_overflow_count + c_CNT_ONE;
    end
  end

  assign overflow_count = r_overflow_count;
`else
  assign bus.s_axis_ts_ready = r_ready_en && !w_full;
  assign overflow_count      = '0;
`endif

  // The !full term only matters in drop mode, where ready ignores fullness.
  assign w_push = bus.s_axis_ts_valid && bus.s_axis_ts_ready && !w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  assign fill_level = r_wr_ptr - r_rd_ptr;

  ptp_ts_fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_push),
    .wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .wr_data (bus.s_axis_ts_96),
    .rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_pop) begin
      r_hold <= w_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tvalid    = 1'b0;
    w_tlast     = 1'b0;
    w_tdata     = '0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_W0;
        end
      end
      ST_W0: begin
        w_tvalid = 1'b1;
        w_tdata  = ts_word(r_hold, 0);
        if (bus.m_axis_tready) begin
          w_state_nxt = ST_W1;
        end
      end
      ST_W1: begin
        w_tvalid = 1'b1;
        w_tdata  = ts_word(r_hold, 1);
        if (bus.m_axis_tready) begin
          w_state_nxt = ST_W2;
        end
      end
      ST_W2: begin
        w_tvalid = 1'b1;
        w_tlast  = 1'b1;
        w_tdata  = ts_word(r_hold, 2);
        // Reload straight from the RAM so consecutive timestamps have no bubble.
        if (bus.m_axis_tready) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_W0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.m_axis_tdata  = w_tdata;
  assign bus.m_axis_tvalid = w_tvalid;
  assign bus.m_axis_tlast  = w_tlast;

endmodule

`default_nettype wire

// File: tb/tb_ptp_ts_word_fifo.sv
// ============================================================================
// Module      : tb_ptp_ts_word_fifo
// Description : Self-checking bench for ptp_ts_word_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ptp_ts_word_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W:0]   fill_level;
  logic [CNT_W-1:0]  overflow_count;
  int                checks = 0;
  int                failures = 0;

  ptp_ts_word_fifo_if bus ();

  ptp_ts_word_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .fill_level     (fill_level),
    .overflow_count (overflow_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [95:0] ts;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] mk_ts(input int i);
    return {32'(i), 32'h1000_0000 | 32'(i), 32'hA5A5_0000 | 32'(i)};
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    bus.m_axis_tready = 1'b1;
    while ((bus.m_axis_tvalid || fill_level != 0) && n < 200) begin
      tick();
      n++;
    end
    check({name, " drain_done"}, (n < 200), 1'b1);
  endtask

  initial begin
    logic [31:0] exp_q [$];
    logic [31:0] exp_w;
    logic [95:0] r_ts;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    int          pushed;
    int          widx;
    int          npush;

    vecs[0] = '{ts: 96'h0000_0000_0001_2345_6789_ABCD, w0: 32'h0000_0000, w1: 32'h0001_2345, w2: 32'h6789_ABCD};
    vecs[1] = '{ts: 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, w0: 32'hFFFF_FFFF, w1: 32'hFFFF_FFFF, w2: 32'hFFFF_FFFF};
    vecs[2] = '{ts: 96'h0123_4567_89AB_CDEF_0011_2233, w0: 32'h0123_4567, w1: 32'h89AB_CDEF, w2: 32'h0011_2233};
    vecs[3] = '{ts: 96'h8000_0001_0000_0002_4000_0003, w0: 32'h8000_0001, w1: 32'h0000_0002, w2: 32'h4000_0003};

    bus.s_axis_ts_96    = '0;
    bus.s_axis_ts_valid = 1'b0;
    bus.m_axis_tready   = 1'b0;

    // Reset state
    #12;
    check("rst_ready", bus.s_axis_ts_ready, 1'b0);
    check("rst_tvalid", bus.m_axis_tvalid, 1'b0);
    check("rst_tlast", bus.m_axis_tlast, 1'b0);
    check("rst_tdata", bus.m_axis_tdata, 32'h0);
    check("rst_fill", fill_level, 5'd0);
    check("rst_ovf", overflow_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", bus.s_axis_ts_ready, 1'b1);

    // Table: single timestamps, latency and word order with tready=1
    bus.m_axis_tready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      check($sformatf("v%0d_ready", v), bus.s_axis_ts_ready, 1'b1);
      bus.s_axis_ts_96    = vecs[v].ts;
      bus.s_axis_ts_valid = 1'b1;
      tick();
      bus.s_axis_ts_valid = 1'b0;
      check($sformatf("v%0d_n1_tvalid", v), bus.m_axis_tvalid, 1'b0);
      check($sformatf("v%0d_n1_fill", v), fill_level, 5'd1);
      tick();
      check($sformatf("v%0d_w0_tvalid", v), bus.m_axis_tvalid, 1'b1);
      check($sformatf("v%0d_w0", v), bus.m_axis_tdata, vecs[v].w0);
      check($sformatf("v%0d_w0_tlast", v), bus.m_axis_tlast, 1'b0);
      check($sformatf("v%0d_n2_fill", v), fill_level, 5'd0);
      tick();
      check($sformatf("v%0d_w1", v), bus.m_axis_tdata, vecs[v].w1);
      check($sformatf("v%0d_w1_tlast", v), bus.m_axis_tlast, 1'b0);
      tick();
      check($sformatf("v%0d_w2", v), bus.m_axis_tdata, vecs[v].w2);
      check($sformatf("v%0d_w2_tlast", v), bus.m_axis_tlast, 1'b1);
      tick();
      check($sformatf("v%0d_end_tvalid", v), bus.m_axis_tvalid, 1'b0);
    end

    // Fill to full with tready=0, then release
    bus.m_axis_tready = 1'b0;
`ifdef PTP_TS_FIFO_DROP_EN
    npush = 20;
`else
    npush = 17;
`endif
    for (int i = 0; i < npush; i++) begin
      bus.s_axis_ts_96    = mk_ts(i);
      bus.s_axis_ts_valid = 1'b1;
      tick();
      if (i == 15) begin
        check("fill_after16", fill_level, 5'd15);
        check("ready_after16", bus.s_axis_ts_ready, 1'b1);
      end
      if (i == 16) begin
        check("fill_after17", fill_level, 5'd16);
`ifdef PTP_TS_FIFO_DROP_EN
        check("ready_full_drop", bus.s_axis_ts_ready, 1'b1);
`else
        check("ready_full", bus.s_axis_ts_ready, 1'b0);
`endif
      end
    end
    bus.s_axis_ts_valid = 1'b0;
    check("fill_final", fill_level, 5'd16);
`ifdef PTP_TS_FIFO_DROP_EN
    check("ovf_count", overflow_count, 16'd3);
    check("ready_stays", bus.s_axis_ts_ready, 1'b1);
`else
    check("ovf_zero", overflow_count, 16'd0);
`endif
    check("stall_tvalid", bus.m_axis_tvalid, 1'b1);
    check("stall_tdata", bus.m_axis_tdata, 32'h0);
    bus.m_axis_tready = 1'b1;
    for (int k = 0; k < 51; k++) begin
      r_ts = mk_ts(k / 3);
      exp_w = r_ts[32*(2 - (k % 3)) +: 32];
      check($sformatf("burst_tvalid_%0d", k), bus.m_axis_tvalid, 1'b1);
      check($sformatf("burst_tdata_%0d", k), bus.m_axis_tdata, exp_w);
      check($sformatf("burst_tlast_%0d", k), bus.m_axis_tlast, ((k % 3) == 2));
      tick();
    end
    check("burst_end_tvalid", bus.m_axis_tvalid, 1'b0);
    check("burst_end_fill", fill_level, 5'd0);

    // Simultaneous push and pop at fill_level=4
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.s_axis_ts_96    = mk_ts(100 + i);
      bus.s_axis_ts_valid = 1'b1;
      tick();
    end
    bus.s_axis_ts_valid = 1'b0;
    check("pp_fill_pre", fill_level, 5'd4);
    bus.m_axis_tready = 1'b1;
    tick();
    tick();
    check("pp_w2_tlast", bus.m_axis_tlast, 1'b1);
    check("pp_fill_w2", fill_level, 5'd4);
    bus.s_axis_ts_96    = mk_ts(105);
    bus.s_axis_ts_valid = 1'b1;
    tick();
    bus.s_axis_ts_valid = 1'b0;
    check("pp_fill_post", fill_level, 5'd4);
    check("pp_next_w0", bus.m_axis_tdata, 32'd101);
    check("pp_next_tlast", bus.m_axis_tlast, 1'b0);
    drain("pp");

    // Random tready, push every 2 clocks, scoreboard and stability
    pushed     = 0;
    widx       = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (prev_stall) begin
        check("rnd_hold_tvalid", bus.m_axis_tvalid, 1'b1);
        check("rnd_hold_tdata", bus.m_axis_tdata, prev_data);
        check("rnd_hold_tlast", bus.m_axis_tlast, prev_last);
      end
      bus.m_axis_tready = 1'($urandom_range(0, 1));
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_word", bus.m_axis_tvalid, 1'b0);
        end else begin
          exp_w = exp_q.pop_front();
          check("rnd_tdata", bus.m_axis_tdata, exp_w);
          check("rnd_tlast", bus.m_axis_tlast, (widx == 2));
        end
        widx = (widx == 2) ? 0 : widx + 1;
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_data  = bus.m_axis_tdata;
      prev_last  = bus.m_axis_tlast;
      if (pushed < 12 && (cyc % 2) == 0) begin
        r_ts = {$urandom, $urandom, $urandom};
        bus.s_axis_ts_96    = r_ts;
        bus.s_axis_ts_valid = 1'b1;
        if (bus.s_axis_ts_ready) begin
          exp_q.push_back(r_ts[95:64]);
          exp_q.push_back(r_ts[63:32]);
          exp_q.push_back(r_ts[31:0]);
          pushed++;
        end
      end else begin
        bus.s_axis_ts_valid = 1'b0;
      end
      tick();
      if (pushed == 12 && exp_q.size() == 0) begin
        break;
      end
    end
    bus.s_axis_ts_valid = 1'b0;
    check("rnd_all_pushed", pushed, 12);
    check("rnd_queue_empty", exp_q.size(), 0);
    check("rnd_end_tvalid", bus.m_axis_tvalid, 1'b0);

    // Reset asserted while in W1
    bus.m_axis_tready   = 1'b1;
    bus.s_axis_ts_96    = mk_ts(200);
    bus.s_axis_ts_valid = 1'b1;
    tick();
    bus.s_axis_ts_96 = mk_ts(201);
    tick();
    bus.s_axis_ts_valid = 1'b0;
    check("rst6_w0", bus.m_axis_tdata, 32'd200);
    tick();
    check("rst6_w1", bus.m_axis_tdata, 32'h1000_00C8);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst6_tvalid", bus.m_axis_tvalid, 1'b0);
    check("rst6_fill", fill_level, 5'd0);
    check("rst6_tlast", bus.m_axis_tlast, 1'b0);
    check("rst6_tdata", bus.m_axis_tdata, 32'h0);
    check("rst6_ready", bus.s_axis_ts_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst6_ready_back", bus.s_axis_ts_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rst6_no_stale_%0d", i), bus.m_axis_tvalid, 1'b0);
      check($sformatf("rst6_empty_%0d", i), fill_level, 5'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
